// File: rtl/enable_pulse_generator_if.sv
// rtl/enable_pulse_generator_if.sv - counter, config and enable-output bundle; ENABLE_PULSE_OVERRUN_EN adds overrun_flag
interface enable_pulse_generator_if #(
    parameter int COUNTER_WIDTH = 32,
    parameter int N_CHANNELS    = 2
);
    logic                                gen_enable_in;
    logic [COUNTER_WIDTH-1:0]            counter_in;
    logic [N_CHANNELS*COUNTER_WIDTH-1:0] thresholds;
    logic [COUNTER_WIDTH-1:0]            pulse_width;
    logic [N_CHANNELS-1:0]               channel_mask;
    logic [N_CHANNELS-1:0]               enable_out;
`ifdef ENABLE_PULSE_OVERRUN_EN
    logic [N_CHANNELS-1:0]               overrun_flag;

    modport master (
        output gen_enable_in, counter_in, thresholds, pulse_width, channel_mask,
        input  enable_out, overrun_flag
    );
    modport slave (
        input  gen_enable_in, counter_in, thresholds, pulse_width, channel_mask,
        output enable_out, overrun_flag
    );
`else
    modport master (
        output gen_enable_in, counter_in, thresholds, pulse_width, channel_mask,
        input  enable_out
    );
    modport slave (
        input  gen_enable_in, counter_in, thresholds, pulse_width, channel_mask,
        output enable_out
    );
`endif
endinterface

// File: rtl/enable_pulse_generator.sv
// rtl/enable_pulse_generator.sv - per-channel threshold-triggered enable pulses; ENABLE_PULSE_OVERRUN_EN adds sticky overrun flags
module enable_pulse_generator #(
    parameter int COUNTER_WIDTH = 32,
    parameter int N_CHANNELS    = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    enable_pulse_generator_if.slave  bus
);
    localparam int CW = COUNTER_WIDTH;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_PULSE = 1'b1
    } state_t;

    logic                    w_load;
    logic [N_CHANNELS*CW-1:0] r_thr_sh;
    logic [N_CHANNELS*CW-1:0] w_thr_eff;
    logic [CW-1:0]           r_pw_sh;
    logic [CW-1:0]           w_pw_eff;
    logic [N_CHANNELS-1:0]   r_mask_sh;
    logic [N_CHANNELS-1:0]   w_mask_eff;
    logic [N_CHANNELS-1:0]   w_match;
    logic [N_CHANNELS-1:0]   r_match_d;
    logic [N_CHANNELS-1:0]   w_trigger;
    logic [N_CHANNELS-1:0]   w_retrigger;
    logic [N_CHANNELS-1:0]   w_enable;
    state_t                  r_state     [N_CHANNELS];
    state_t                  w_state_nxt [N_CHANNELS];
    logic [CW-1:0]           r_width     [N_CHANNELS];
    logic [CW-1:0]           w_width_nxt [N_CHANNELS];

    // Shadows follow the bus while stopped and at wrap; the value being loaded is used that same cycle.
    assign w_load     = ~bus.gen_enable_in | (bus.counter_in == '0);
    assign w_thr_eff  = w_load ? bus.thresholds   : r_thr_sh;
    assign w_pw_eff   = w_load ? bus.pulse_width  : r_pw_sh;
    assign w_mask_eff = w_load ? bus.channel_mask : r_mask_sh;

    always_comb begin
        w_match = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            w_match[i] = (bus.counter_in == w_thr_eff[i*CW +: CW]);
        end
    end

    assign w_trigger = w_match & ~r_match_d & {N_CHANNELS{bus.gen_enable_in}}
                     & w_mask_eff & {N_CHANNELS{w_pw_eff != '0}};

    always_comb begin
        w_retrigger = '0;
        w_enable    = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            w_state_nxt[i] = r_state[i];
            w_width_nxt[i] = r_width[i];
            w_enable[i]    = (r_state[i] == ST_PULSE);
            case (r_state[i])
                ST_IDLE: begin
                    if (w_trigger[i]) begin
                        w_state_nxt[i] = ST_PULSE;
                        w_width_nxt[i] = CW'(1);
                    end
                end
                ST_PULSE: begin
                    w_retrigger[i] = w_trigger[i];
                    // >= so a width shrunk at wrap mid-pulse ends the pulse instead of stretching it.
                    if (r_width[i] >= w_pw_eff) begin
                        w_state_nxt[i] = ST_IDLE;
                        w_width_nxt[i] = '0;
                    end else begin
                        w_width_nxt[i] = r_width[i] + CW'(1);
                    end
                end
                default: begin
                    w_state_nxt[i] = ST_IDLE;
                    w_width_nxt[i] = '0;
                end
            endcase
            if (!bus.gen_enable_in) begin
                w_state_nxt[i] = ST_IDLE;
                w_width_nxt[i] = '0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_thr_sh  <= '0;
            r_pw_sh   <= '0;
            r_mask_sh <= '0;
            r_match_d <= '0;
            for (int i = 0; i < N_CHANNELS; i++) begin
                r_state[i] <= ST_IDLE;
                r_width[i] <= '0;
            end
        end else begin
            r_thr_sh  <= w_thr_eff;
            r_pw_sh   <= w_pw_eff;
            r_mask_sh <= w_mask_eff;
            // Cleared while stopped so a counter already sitting on a threshold fires at enable.
            r_match_d <= bus.gen_enable_in ? w_match : '0;
            for (int i = 0; i < N_CHANNELS; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_width[i] <= w_width_nxt[i];
            end
        end
    end

    assign bus.enable_out = w_enable;

`ifdef ENABLE_PULSE_OVERRUN_EN
    logic [N_CHANNELS-1:0] r_overrun;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_overrun <= '0;
        end else if (!bus.gen_enable_in) begin
            r_overrun <= '0;
        end else begin
            r_overrun <= r_overrun | w_retrigger;
        end
    end

    assign bus.overrun_flag = r_overrun;
`else
    logic w_unused_retrigger;
    assign w_unused_retrigger = ^w_retrigger;
`endif
endmodule

// File: tb/tb_enable_pulse_generator.sv
// tb/tb_enable_pulse_generator.sv - directed checks of enable_pulse_generator; ENABLE_PULSE_OVERRUN_EN adds overrun checks
module tb_enable_pulse_generator;
    localparam int CW  = 32;
    localparam int NCH = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clock = ~clock;

    enable_pulse_generator_if #(.COUNTER_WIDTH(CW), .N_CHANNELS(NCH)) bus ();

    enable_pulse_generator #(.COUNTER_WIDTH(CW), .N_CHANNELS(NCH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_ovr(input string tag, input logic [1:0] exp);
`ifdef ENABLE_PULSE_OVERRUN_EN
        check(tag, bus.overrun_flag, exp);
`else
        if (exp !== 2'bxx) n_checks += 0;
`endif
    endtask

    task automatic set_cfg(input int thr0, input int thr1, input int pw, input logic [1:0] mask);
        bus.thresholds   = {thr1[CW-1:0], thr0[CW-1:0]};
        bus.pulse_width  = pw[CW-1:0];
        bus.channel_mask = mask;
    endtask

    // Drive one counter cycle just after the edge, return at the following negedge for sampling.
    task automatic cyc(input int c, input logic ge);
        @(posedge clock);
        #1;
        bus.counter_in    = c[CW-1:0];
        bus.gen_enable_in = ge;
        @(negedge clock);
    endtask

    int          stall_c [14] = '{0, 1, 2, 3, 4, 5, 5, 5, 5, 6, 7, 8, 9, 0};
    int          stall_e [14] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    int          post_c  [7]  = '{4, 5, 0, 1, 2, 3, 4};
    int          post_e  [7]  = '{0, 0, 0, 0, 0, 1, 1};
    logic        e0, e1;

    initial begin
        bus.gen_enable_in = 1'b0;
        bus.counter_in    = '0;
        set_cfg(5, 100, 3, 2'b11);
        #3;
        check("reset_en", bus.enable_out, 2'b00);
        check_ovr("reset_ovr", 2'b00);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;

        // thr0=5 pw=3 then thr0->7 and thr1->0 at counter 3 of period 3
        for (int p = 1; p <= 5; p++) begin
            for (int c = 0; c < 10; c++) begin
                if (p == 3 && c == 3) set_cfg(7, 0, 3, 2'b11);
                cyc(c, 1'b1);
                if (p <= 3) e0 = (c >= 6 && c <= 8);
                else        e0 = (c == 8 || c == 9 || (c == 0 && p == 5));
                e1 = (p >= 4) && (c >= 1 && c <= 3);
                check($sformatf("thr p%0d c%0d", p, c), bus.enable_out, {e1, e0});
            end
        end

        // stop the generator while ch0 is on its last pulse clock
        set_cfg(5, 100, 2, 2'b01);
        cyc(0, 1'b0);
        check("stop_first", bus.enable_out, 2'b01);
        cyc(0, 1'b0);
        check("stop_idle", bus.enable_out, 2'b00);

        // stalled timebase holds counter at the threshold
        for (int k = 0; k < 14; k++) begin
            cyc(stall_c[k], 1'b1);
            check($sformatf("stall k%0d", k), bus.enable_out, {1'b0, stall_e[k][0]});
        end

        // period 6, thr0=2, pw=8: retrigger mid-pulse ignored, then stop mid-pulse
        set_cfg(2, 100, 8, 2'b01);
        cyc(0, 1'b0);
        check("ovr_pre", bus.enable_out, 2'b00);
        for (int k = 0; k <= 22; k++) begin
            cyc(k % 6, (k <= 20));
            e0 = (k >= 3 && k <= 10) || (k >= 15 && k <= 21);
            check($sformatf("long k%0d", k), bus.enable_out, {1'b0, e0});
            check_ovr($sformatf("ovr k%0d", k), {1'b0, (k >= 9 && k <= 21)});
        end

        // re-enable fires normally
        for (int c = 0; c < 6; c++) begin
            cyc(c, 1'b1);
            check($sformatf("reen c%0d", c), bus.enable_out, {1'b0, (c >= 3)});
            check_ovr($sformatf("reen_ovr c%0d", c), 2'b00);
        end
        cyc(0, 1'b1);
        check("pre_reset", bus.enable_out, 2'b01);

        // asynchronous reset in the middle of a pulse
        #1;
        reset = 1'b0;
        #1;
        check("async_reset", bus.enable_out, 2'b00);
        for (int c = 1; c <= 3; c++) begin
            cyc(c, 1'b1);
            check($sformatf("in_reset c%0d", c), bus.enable_out, 2'b00);
        end
        #2;
        reset = 1'b1;
        for (int k = 0; k < 7; k++) begin
            cyc(post_c[k], 1'b1);
            check($sformatf("post_reset k%0d", k), bus.enable_out, {1'b0, post_e[k][0]});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
